// File: rtl/rtc_seg_pkg.sv
// Shared constants and BCD helpers for the RTC / seven-segment block.
package rtc_seg_pkg;

    localparam logic [1:0] ADDR_TIME   = 2'd0;
    localparam logic [1:0] ADDR_ALARM  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_ALM_EN = 1;
    localparam int CTRL_BLANK  = 2;
    localparam int STAT_PEND   = 0;

    // Active-high gfedcba pattern; anything outside 0-9 is dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Returns {carry, next}; values at or past the limit wrap, so junk recovers.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [8:0] r;
        if (v >= lim)
            r = 9'h100;
        else if (v[3:0] >= 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_press <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/rtc_seg_mux.sv
// BCD real-time clock with alarm, Avalon-MM registers and a scanned
// seven-segment display driver.
module rtc_seg_mux #(
    parameter int CLK_FREQ_HZ    = 50000000,
    parameter int REFRESH_HZ     = 1000,
    parameter int N_DIGITS       = 6,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYC   = 500000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    input  logic [2:0]          btn,
    output logic [7:0]          seg,
    output logic [N_DIGITS-1:0] dig_sel,
    output logic                tick_1hz,
    output logic                irq
);
    import rtc_seg_pkg::*;

    localparam int   PW       = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int   SCAN_DIV = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int   SW       = $clog2(SCAN_DIV + 1);
    localparam int   IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic POL      = (SEG_ACTIVE_LOW != 0);

    logic [23:0]         r_time;
    logic [23:0]         r_alarm;
    logic [2:0]          r_ctrl;
    logic                r_pend;
    logic                r_match_q;
    logic [PW-1:0]       r_presc;
    logic                r_tick;
    logic [SW-1:0]       r_scan_cnt;
    logic [IW-1:0]       r_idx;
    logic [7:0]          r_seg;
    logic [N_DIGITS-1:0] r_dig;
    logic [31:0]         r_rdata;

    logic [2:0]          w_press;
    logic                w_run;
    logic                w_tick;
    logic                w_wr_time;
    logic                w_clr_pend;
    logic                w_match;
    logic [8:0]          w_ss;
    logic [8:0]          w_mm;
    logic [8:0]          w_hh;
    logic [23:0]         w_time_nx;
    logic [31:0]         w_disp;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic [7:0]          w_seg;
    logic [N_DIGITS-1:0] w_dig;
    logic                w_unused;

    for (genvar g = 0; g < 3; g++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk     (clk),
            .reset   (reset),
            .i_btn_n (btn[g]),
            .o_press (w_press[g])
        );
    end

    assign w_run      = r_ctrl[CTRL_RUN];
    assign w_tick     = w_run && (r_presc == PW'(CLK_FREQ_HZ - 1));
    assign w_wr_time  = avs_write && (avs_address == ADDR_TIME);
    assign w_clr_pend = avs_write && (avs_address == ADDR_STATUS)
                        && avs_writedata[STAT_PEND];
    assign w_match    = (r_time == r_alarm);
    assign w_ss       = bcd_inc(r_time[7:0], 8'h59);
    assign w_mm       = bcd_inc(r_time[15:8], 8'h59);
    assign w_hh       = bcd_inc(r_time[23:16], 8'h23);
    assign w_unused   = &{1'b0, avs_writedata[31:24]};

    // A bus write beats the buttons, which beat the tick; losers are dropped.
    always_comb begin
        w_time_nx = r_time;
        if (w_wr_time) begin
            w_time_nx = avs_writedata[23:0];
        end else if (|w_press) begin
            if (w_press[0]) w_time_nx[23:16] = w_hh[7:0];
            if (w_press[1]) w_time_nx[15:8]  = w_mm[7:0];
            if (w_press[2]) w_time_nx[7:0]   = 8'h00;
        end else if (w_tick) begin
            w_time_nx[7:0] = w_ss[7:0];
            if (w_ss[8]) begin
                w_time_nx[15:8] = w_mm[7:0];
                if (w_mm[8]) w_time_nx[23:16] = w_hh[7:0];
            end
        end
    end

    always_comb begin
        w_disp = (N_DIGITS == 4) ? {16'h0, r_time[23:8]} : {8'h0, r_time};
        w_nib  = w_disp[{r_idx, 2'b00} +: 4];
        w_dp   = !r_time[0] &&
                 (((N_DIGITS == 6) && (r_idx == IW'(2) || r_idx == IW'(4))) ||
                  ((N_DIGITS == 4) && (r_idx == IW'(2))));
        w_seg  = {w_dp, bcd_to_seg(w_nib)};
        w_dig  = N_DIGITS'(1) << r_idx;
        if (r_ctrl[CTRL_BLANK]) begin
            w_seg = '0;
            w_dig = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_time     <= '0;
            r_alarm    <= '0;
            r_ctrl     <= 3'b001;
            r_pend     <= 1'b0;
            r_match_q  <= 1'b1;
            r_presc    <= '0;
            r_tick     <= 1'b0;
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_seg      <= {8{POL}};
            r_dig      <= N_DIGITS'(1) ^ {N_DIGITS{POL}};
            r_rdata    <= '0;
        end else begin
            r_time <= w_time_nx;
            r_tick <= w_tick;

            if (w_wr_time || w_press[2])
                r_presc <= '0;
            else if (w_run)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;

            if (avs_write) begin
                case (avs_address)
                    ADDR_ALARM: r_alarm <= avs_writedata[23:0];
                    ADDR_CTRL:  r_ctrl  <= avs_writedata[2:0];
                    default:    ;
                endcase
            end

            // Only a fresh match raises the flag, and it wins over a clear.
            r_match_q <= w_match;
            if (w_match && !r_match_q)
                r_pend <= 1'b1;
            else if (w_clr_pend)
                r_pend <= 1'b0;

            if (avs_read) begin
                case (avs_address)
                    ADDR_TIME:  r_rdata <= {8'h0, r_time};
                    ADDR_ALARM: r_rdata <= {8'h0, r_alarm};
                    ADDR_CTRL:  r_rdata <= {29'h0, r_ctrl};
                    default:    r_rdata <= {31'h0, r_pend};
                endcase
            end

            if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            r_seg <= w_seg ^ {8{POL}};
            r_dig <= w_dig ^ {N_DIGITS{POL}};
        end
    end

    assign avs_readdata = r_rdata;
    assign seg          = r_seg;
    assign dig_sel      = r_dig;
    assign tick_1hz     = r_tick;
    assign irq          = r_pend && r_ctrl[CTRL_ALM_EN];

endmodule

// File: tb/tb_rtc_seg_mux.sv
// Bench for rtc_seg_mux: register vectors, rollover, alarm, buttons,
// display scan and mid-run reset, with reads checked through a scoreboard.
module tb_rtc_seg_mux;

    localparam int ND = 6;
    localparam logic [1:0] A_TIME = 2'd0;
    localparam logic [1:0] A_ALRM = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic [2:0]    btn = 3'b111;
    logic [7:0]    seg;
    logic [ND-1:0] dig_sel;
    logic          tick_1hz;
    logic          irq;

    always #5 clk = ~clk;

    rtc_seg_mux #(
        .CLK_FREQ_HZ    (20),
        .REFRESH_HZ     (5),
        .N_DIGITS       (ND),
        .SEG_ACTIVE_LOW (1),
        .DEBOUNCE_CYC   (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .btn           (btn),
        .seg           (seg),
        .dig_sel       (dig_sel),
        .tick_1hz      (tick_1hz),
        .irq           (irq)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic rd_seen = 1'b0;

    typedef struct {
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];
    logic [7:0] exp_seg[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Read data is due one cycle after the strobe is sampled.
    always @(posedge clk) rd_seen <= avs_read && !reset;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h, nothing queued", avs_readdata);
            end else begin
                check("avs_read", avs_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!tick_1hz && cyc < 100);
        if (!tick_1hz) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: no tick_1hz within %0d cycles", cyc);
        end
    endtask

    task automatic press(input int b);
        btn[b] = 1'b0;
        idle(10);
        btn[b] = 1'b1;
        idle(10);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h0000_00FF);
        check({tag, "_dig"}, 32'(dig_sel), 32'h0000_003E);
        check({tag, "_tick"}, 32'(tick_1hz), 32'h0);
        check({tag, "_irq"}, 32'(irq), 32'h0);
        check({tag, "_rdata"}, avs_readdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int to;
        logic [5:0] exp_dig;

        vecs[0] = '{A_CTRL, 32'h0000_0000, A_CTRL, 32'h0000_0000};
        vecs[1] = '{A_TIME, 32'hFF12_3456, A_TIME, 32'h0012_3456};
        vecs[2] = '{A_ALRM, 32'hAB00_0001, A_ALRM, 32'h0000_0001};
        vecs[3] = '{A_CTRL, 32'hFFFF_FFF2, A_CTRL, 32'h0000_0002};
        vecs[4] = '{A_TIME, 32'h0000_0001, A_STAT, 32'h0000_0001};
        vecs[5] = '{A_STAT, 32'h0000_0000, A_STAT, 32'h0000_0001};
        vecs[6] = '{A_STAT, 32'h0000_0001, A_STAT, 32'h0000_0000};
        vecs[7] = '{A_TIME, 32'h0000_007A, A_TIME, 32'h0000_007A};
        vecs[8] = '{A_CTRL, 32'h0000_0000, A_STAT, 32'h0000_0000};

        exp_seg[0] = 8'h82;
        exp_seg[1] = 8'h92;
        exp_seg[2] = 8'h19;
        exp_seg[3] = 8'hB0;
        exp_seg[4] = 8'h24;
        exp_seg[5] = 8'hF9;

        idle(3);
        check_reset_outputs("rst0");
        reset = 1'b0;
        rd(A_TIME, 32'h0);
        rd(A_ALRM, 32'h0);
        rd(A_CTRL, 32'h1);
        rd(A_STAT, 32'h0);

        for (int i = 0; i < 9; i++) begin
            wr(vecs[i].wa, vecs[i].wd);
            idle(1);
            rd(vecs[i].ra, vecs[i].exp);
        end

        // 23:59:58 rolls through two ticks to midnight.
        wr(A_CTRL, 32'h1);
        wr(A_TIME, 32'h0023_5958);
        wait_tick(c);
        check("roll_tick1_gap", 32'(c), 32'd20);
        wait_tick(c);
        check("roll_tick2_gap", 32'(c), 32'd20);
        idle(1);
        check("tick_width", 32'(tick_1hz), 32'h0);
        rd(A_TIME, 32'h0000_0000);

        // Alarm at 00:00:05 from 00:00:03.
        wr(A_ALRM, 32'h0000_0005);
        wr(A_STAT, 32'h1);
        wr(A_CTRL, 32'h3);
        wr(A_TIME, 32'h0000_0003);
        wait_tick(c);
        check("irq_after_1tick", 32'(irq), 32'h0);
        wait_tick(c);
        check("irq_at_match", 32'(irq), 32'h0);
        idle(1);
        check("irq_after_match", 32'(irq), 32'h1);
        wr(A_STAT, 32'h1);
        check("irq_cleared", 32'(irq), 32'h0);
        rd(A_STAT, 32'h0);

        // TIME write and read landing on a tick edge.
        wr(A_TIME, 32'h0000_0010);
        wait_tick(c);
        idle(19);
        avs_address   = A_TIME;
        avs_writedata = 32'h0000_0042;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        exp_q.push_back(32'h0000_0011);
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        rd(A_TIME, 32'h0000_0042);
        wait_tick(c);
        check("collide_next_tick", 32'(c), 32'd19);
        rd(A_TIME, 32'h0000_0043);
        idle(5);
        wr(A_TIME, 32'h0000_0100);
        wait_tick(c);
        check("wr_restarts_presc", 32'(c), 32'd20);

        // Buttons, with run off so only button actions move the time.
        wr(A_CTRL, 32'h0);
        wr(A_TIME, 32'h0010_5900);
        btn[1] = 1'b0;
        idle(2);
        btn[1] = 1'b1;
        idle(3);
        btn[1] = 1'b0;
        idle(10);
        btn[1] = 1'b1;
        idle(10);
        rd(A_TIME, 32'h0010_0000);
        wr(A_TIME, 32'h0023_5930);
        press(0);
        rd(A_TIME, 32'h0000_5930);
        press(1);
        rd(A_TIME, 32'h0000_0030);
        press(2);
        rd(A_TIME, 32'h0000_0000);

        // Display scan of 12:34:56.
        wr(A_TIME, 32'h0012_3456);
        to = 0;
        while (dig_sel == 6'b111110 && to < 40) begin
            @(negedge clk);
            to++;
        end
        while (dig_sel != 6'b111110 && to < 40) begin
            @(negedge clk);
            to++;
        end
        check("scan_sync", 32'(dig_sel), 32'h3E);
        check("scan_seg0", 32'(seg), 32'(exp_seg[0]));
        for (int k = 1; k < 6; k++) begin
            idle(4);
            exp_dig = ~(6'b000001 << k);
            check($sformatf("scan_dig%0d", k), 32'(dig_sel), 32'(exp_dig));
            check($sformatf("scan_seg%0d", k), 32'(seg), 32'(exp_seg[k]));
        end
        idle(4);
        check("scan_wrap", 32'(dig_sel), 32'h3E);
        wr(A_CTRL, 32'h4);
        idle(1);
        check("blank_dig", 32'(dig_sel), 32'h3F);
        check("blank_seg", 32'(seg), 32'hFF);

        // Reset in the middle of a running, alarmed state.
        wr(A_CTRL, 32'h3);
        wr(A_ALRM, 32'h0010_1010);
        wr(A_TIME, 32'h0010_1010);
        idle(1);
        check("irq_pre_reset", 32'(irq), 32'h1);
        rd(A_TIME, 32'h0010_1010);
        idle(5);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst1");
        reset = 1'b0;
        rd(A_TIME, 32'h0);
        rd(A_ALRM, 32'h0);
        rd(A_CTRL, 32'h1);
        rd(A_STAT, 32'h0);

        idle(2);
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
